multiphase_clk_divider: RTL and testbench
=========================================

// Module: multiphase_clk_divider
// PURPOSE
//   Parametrised multi-phase clock divider for serializer trees: Johnson counter
//   divides clk_i by 2*PHASES and produces PHASES equally spaced phase outputs
//   (180/PHASES deg apart). Adds enable with stop on a period boundary, illegal-
//   state self-correction, a per-period load strobe and a reset stretcher
//   (deassertion synchronised to clk_i) for downstream divided-clock logic.
// PARAMETERS
//   PHASES    2  Johnson counter length / number of output phases; legal >= 2
//   RST_HOLD  3  clk_i posedges rst_o stays high after rst_i falls; legal >= 1
// PORTS
//   clk_i      in   1       input clock; all state updates on posedge
//   rst_i      in   1       asynchronous active-high reset
//   en_i       in   1       run enable; sampled on posedge
//   clk_o      out  PHASES  divided phases; clk_o[k] = q[k], lags clk_o[0] by k cycles
//   load_o     out  1       1-cycle strobe at start of each divided period
//   running_o  out  1       high while counter advancing or mid-period
//   err_o      out  1       1-cycle pulse: illegal counter state detected and cleared
//   rst_o      out  1       stretched reset; async assert, sync deassert
// BEHAVIOUR
//   Reset (rst_i=1, async): q=0 -> clk_o=0, load_o=0, running_o=0, err_o=0;
//     hold shift reg = all 1s -> rst_o=1 immediately.
//   Reset stretch: after rst_i falls, hold reg shifts in 0 each posedge;
//     rst_o = MSB; rst_o falls exactly RST_HOLD posedges after rst_i falls.
//   Advance condition adv = ~rst_o & (en_i | q!=0), using values sampled at
//     the posedge. While adv: q <= {q[PHASES-2:0], ~q[PHASES-1]}; else q holds.
//   Sequence (PHASES=2) from 00: 01,11,10,00 -> period 4, clk_o[1] 90 deg
//     behind clk_o[0]. Generally period 2*PHASES cycles, 50% duty per phase.
//   Enable: en_i=0 mid-period -> counter finishes the period and stops at q=0
//     (all outputs low, no truncated pulses). en_i re-high before q reaches 0
//     -> no interruption. Start from stopped: first posedge with en_i=1 -> q=0..01.
//   running_o (registered) = 1 when next q != 0 or (adv & en_i); 0 when
//     stopped at q=0 or in reset.
//   load_o (registered): 1 for the single cycle in which q has just moved
//     from nonzero (10..0) to 0 while running; never asserted in reset or stop.
//     With en_i held high: one pulse every 2*PHASES cycles.
//   Legal states: 2*PHASES Johnson codes (contiguous 1s from LSB, or contiguous
//     1s from MSB, incl. all-0/all-1). Illegal q at a posedge (any adv state)
//     -> next q = 0, err_o = 1 for one cycle, load_o = 0 that cycle; counting
//     resumes from 0 next posedge if en_i=1. PHASES=2: no illegal states.
//   Simultaneous: rst_i dominates all; illegal-state check dominates advance.
//   Reset mid-operation: all outputs clear asynchronously within the same
//     cycle; after release counter restarts from q=0 once rst_o falls.
//   Outputs are all register outputs (glitch-free); no combinational path
//     from en_i to any output.
// TESTING
//   1 Reset: rst_i=1 3 cycles then 0, RST_HOLD=3, en_i=1 -> rst_o low on 3rd
//     posedge after release; clk_o stays 00 until then, then 01,11,10,00.
//   2 PHASES=2 free-run 20 cycles -> clk_o[0] period 4, duty 2, clk_o[1] lags
//     1 cycle; load_o pulses every 4 cycles coincident with clk_o==00.
//   3 PHASES=4 free-run -> period 8; clk_o[k] lags clk_o[0] by k cycles;
//     sequence 0001,0011,0111,1111,1110,1100,1000,0000.
//   4 PHASES=4, en_i dropped when q=0011 -> continues to 0000, then holds;
//     running_o falls, one final load_o; en_i=1 -> next q=0001.
//   5 PHASES=4, force q=0101 -> next cycle q=0000, err_o=1 one cycle,
//     load_o=0; then normal sequence resumes.
//   6 rst_i pulsed while q=1110 -> clk_o=0000, rst_o=1 same cycle; restart
//     clean after RST_HOLD posedges, no partial period on any phase.

Source files
------------

// File: rtl/multiphase_clk_divider.sv
// Multi-phase clock divider: a PHASES-bit Johnson counter divides clk_i by 2*PHASES,
// with period-aligned enable, illegal-state recovery, a load strobe and a stretched reset.
module multiphase_clk_divider #(
    parameter int PHASES   = 2,
    parameter int RST_HOLD = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [PHASES-1:0] clk_o,
    output logic              load_o,
    output logic              running_o,
    output logic              err_o,
    output logic              rst_o
);

    localparam logic [PHASES-1:0] ONE  = {{(PHASES-1){1'b0}}, 1'b1};
    localparam logic [PHASES-1:0] LAST = {1'b1, {(PHASES-1){1'b0}}};

    logic [PHASES-1:0]   q;
    logic [PHASES-1:0]   q_inv;
    logic [PHASES-1:0]   q_next;
    logic [RST_HOLD-1:0] hold;
    logic                adv;
    logic                illegal;
    logic                at_last;

    assign clk_o = q;
    assign rst_o = hold[RST_HOLD-1];

    // A Johnson code is a run of 1s anchored at the LSB, or its complement
    // (a run anchored at the MSB); x & (x+1) is zero only for an LSB-anchored run.
    always_comb begin
        q_inv   = ~q;
        illegal = ((q & (q + ONE)) != '0) && ((q_inv & (q_inv + ONE)) != '0);
        adv     = ~rst_o & (en_i | (q != '0));
        at_last = (q == LAST);
        q_next  = q;
        if (illegal) begin
            q_next = '0;
        end else if (adv) begin
            q_next = {q[PHASES-2:0], ~q[PHASES-1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q         <= '0;
            hold      <= '1;
            load_o    <= 1'b0;
            running_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            hold      <= hold << 1;
            q         <= q_next;
            err_o     <= illegal;
            // Wrap from 10..0 back to 0 marks the start of a new divided period.
            load_o    <= ~illegal & adv & at_last;
            running_o <= (q_next != '0) | (adv & en_i);
        end
    end

endmodule

// File: tb/tb_multiphase_clk_divider.sv
// Directed bench for multiphase_clk_divider: PHASES=2 and PHASES=4 instances,
// reset stretch, free run, stop on period boundary, illegal-state recovery, mid-run reset.
module tb_multiphase_clk_divider;

    logic       clk;
    logic       rst2, rst4;
    logic       en2, en4;
    logic [1:0] c2;
    logic [3:0] c4;
    logic       l2, r2, e2, ro2;
    logic       l4, r4, e4, ro4;

    int checks   = 0;
    int failures = 0;

    logic [1:0] seq2 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [3:0] seq4 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};

    multiphase_clk_divider #(.PHASES(2), .RST_HOLD(3)) u2 (
        .clk_i(clk), .rst_i(rst2), .en_i(en2), .clk_o(c2),
        .load_o(l2), .running_o(r2), .err_o(e2), .rst_o(ro2)
    );

    multiphase_clk_divider #(.PHASES(4), .RST_HOLD(3)) u4 (
        .clk_i(clk), .rst_i(rst4), .en_i(en4), .clk_o(c4),
        .load_o(l4), .running_o(r4), .err_o(e4), .rst_o(ro4)
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] c, input logic l,
                        input logic r, input logic e, input logic ro);
        check_eq({tag, " u2.clk_o"}, 32'(c2), 32'(c));
        check_eq({tag, " u2.load_o"}, 32'(l2), 32'(l));
        check_eq({tag, " u2.running_o"}, 32'(r2), 32'(r));
        check_eq({tag, " u2.err_o"}, 32'(e2), 32'(e));
        check_eq({tag, " u2.rst_o"}, 32'(ro2), 32'(ro));
    endtask

    task automatic chk4(input string tag, input logic [3:0] c, input logic l,
                        input logic r, input logic e, input logic ro);
        check_eq({tag, " u4.clk_o"}, 32'(c4), 32'(c));
        check_eq({tag, " u4.load_o"}, 32'(l4), 32'(l));
        check_eq({tag, " u4.running_o"}, 32'(r4), 32'(r));
        check_eq({tag, " u4.err_o"}, 32'(e4), 32'(e));
        check_eq({tag, " u4.rst_o"}, 32'(ro4), 32'(ro));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected values c posedges after reset release, en held high, RST_HOLD=3:
    // rst_o drops at c=3, first count at c=4.
    task automatic exp_after_release(input int c, output logic [1:0] q2, output logic ld2,
                                     output logic [3:0] q4, output logic ld4,
                                     output logic run, output logic ro);
        ro = (c < 3);
        if (c < 4) begin
            q2 = 2'b00; ld2 = 1'b0; q4 = 4'b0000; ld4 = 1'b0; run = 1'b0;
        end else begin
            q2  = seq2[2'((c - 4) % 4)];
            ld2 = (((c - 4) % 4) == 3);
            q4  = seq4[3'((c - 4) % 8)];
            ld4 = (((c - 4) % 8) == 7);
            run = 1'b1;
        end
    endtask

    logic [3:0] stop_q4  [8] = '{4'b0111, 4'b1111, 4'b1110, 4'b1100,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic       stop_l4  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic       stop_r4  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [1:0] stop_q2  [8] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       stop_l2  [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    logic       stop_r2  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] blip_q4  [6] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic       blip_l4  [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        logic [1:0] q2;
        logic [3:0] q4;
        logic       ld2, ld4, run, ro;

        rst2 = 1'b1; rst4 = 1'b1; en2 = 1'b1; en4 = 1'b1;
        repeat (3) tick();
        chk2("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk4("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset stretch then free run on both widths.
        rst2 = 1'b0; rst4 = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            tick();
            exp_after_release(c, q2, ld2, q4, ld4, run, ro);
            chk2($sformatf("run c=%0d", c), q2, ld2, run, 1'b0, ro);
            chk4($sformatf("run c=%0d", c), q4, ld4, run, 1'b0, ro);
        end

        // u4 sits at 0011 and u2 at 11: drop enable, both finish the period and park.
        en2 = 1'b0; en4 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk2($sformatf("stop t=%0d", t), stop_q2[t], stop_l2[t], stop_r2[t], 1'b0, 1'b0);
            chk4($sformatf("stop t=%0d", t), stop_q4[t], stop_l4[t], stop_r4[t], 1'b0, 1'b0);
        end

        en2 = 1'b1; en4 = 1'b1;
        tick();
        chk2("restart", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        chk4("restart", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk2("restart2", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk4("restart2", 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);

        // One-cycle enable drop mid-period must not interrupt the count.
        en4 = 1'b0;
        tick();
        chk4("blip drop", 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
        en4 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            chk4($sformatf("blip t=%0d", t), blip_q4[t], blip_l4[t], 1'b1, 1'b0, 1'b0);
        end

        // Illegal state 0101 is cleared to 0000 with a one-cycle err_o.
        force u4.q = 4'b0101;
        #1;
        release u4.q;
        tick();
        chk4("illegal", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk4("recover1", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk4("recover2", 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);

        tick();
        tick();
        tick();
        chk4("pre-reset", 4'b1110, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-period, then a clean restart after the stretch.
        rst4 = 1'b1;
        #1;
        chk4("async rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("in rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        rst4 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_after_release(c, q2, ld2, q4, ld4, run, ro);
            chk4($sformatf("rerun c=%0d", c), q4, ld4, run, 1'b0, ro);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
